// File: rtl/dbus_ctrl.sv
// dbus_ctrl: memory-stage data-bus controller.
// Turns one load/store request per instruction into a req/gnt/rvld bus access,
// stalls the pipeline until the access completes, and returns the raw read word.
// Optional build macro: DBUS_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped in IDLE and never reach the bus. When it is
// undefined, misalign_o is tied low.
// DATA_BUS_WIDTH defaults to 32 when the build does not define it.
`timescale 1ns/1ps

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module dbus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_vld_i,
  input  logic                       req_we_i,
  input  logic [ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [`DATA_BUS_WIDTH-1:0] req_wdata_i,
  input  logic [2:0]                 req_size_i,
  output logic                       stall_o,
  output logic [`DATA_BUS_WIDTH-1:0] rdata_o,
  output logic                       rdata_vld_o,
  output logic                       err_o,
  output logic                       misalign_o,
  output logic                       dbus_req_o,
  output logic                       dbus_we_o,
  output logic [ADDR_WIDTH-1:0]      dbus_addr_o,
  output logic [3:0]                 dbus_be_o,
  output logic [`DATA_BUS_WIDTH-1:0] dbus_wdata_o,
  input  logic                       dbus_gnt_i,
  input  logic                       dbus_rvld_i,
  input  logic [`DATA_BUS_WIDTH-1:0] dbus_rdata_i
);

  localparam int unsigned DW = `DATA_BUS_WIDTH;

  // Last count value before the access is abandoned (counter starts at 0 in REQ).
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Byte enables from the one-hot size {word,half,byte} and the low address bits.
  // Malformed sizes (no bit or several bits set) enable no byte but still complete.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      3'b001:  be = 4'b0001 << lo;
      3'b010:  be = lo[1] ? 4'b1100 : 4'b0011;
      3'b100:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

`ifdef DBUS_MISALIGN_TRAP_EN
  // Half on an odd byte, or word off a word boundary.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
    return ((size == 3'b010) && lo[0]) || ((size == 3'b100) && (lo != 2'b00));
  endfunction
`endif

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  rvld_q, rvld_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;
  logic                  timeout;

  assign timeout = (cnt_q == TO_LAST);

  // Next-state, request latch, timeout counter and the DONE-cycle pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    err_d   = 1'b0;
    mis_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_vld_i) begin
          we_d    = req_we_i;
          addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          be_d    = byte_en(req_size_i, req_addr_i[1:0]);
          wdata_d = req_wdata_i;
`ifdef DBUS_MISALIGN_TRAP_EN
          if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
            // Trapped: skip the bus entirely and report in DONE.
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
`else
          state_d = REQ;
          cnt_d   = '0;
`endif
        end
      end

      REQ: begin
        if (dbus_gnt_i && (we_q || dbus_rvld_i)) begin
          // Store granted, or load granted with data in the same cycle.
          state_d = DONE;
          if (!we_q) begin
            rdata_d = dbus_rdata_i;
            rvld_d  = 1'b1;
          end
        end else if (timeout) begin
          // A grant without data does not count as completion.
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (dbus_gnt_i) begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (dbus_rvld_i) begin
          state_d = DONE;
          rdata_d = dbus_rdata_i;
          rvld_d  = 1'b1;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        // req_vld_i here still belongs to the finishing instruction.
        state_d = IDLE;
      end
    endcase
  end

  // FSM and all registered outputs; synchronous reset abandons any access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Only IDLE stalls combinationally: the pipeline must hold an instruction
  // that has just arrived until the bus access finishes in DONE.
  always_comb begin
    unique case (state_q)
      IDLE:    stall_o = req_vld_i;
      DONE:    stall_o = 1'b0;
      default: stall_o = 1'b1;
    endcase
  end

  assign dbus_req_o   = (state_q == REQ);
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;
  assign rdata_vld_o  = rvld_q;
  assign err_o        = err_q;

`ifdef DBUS_MISALIGN_TRAP_EN
  assign misalign_o = mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl: directed scenarios with literal expectations followed by a
// randomized pipeline/bus run, all checked every cycle against a
// transaction-level model of the controller.
`timescale 1ns/1ps

`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module tb_dbus_ctrl;

  localparam int TO = 4;
  localparam int AW = 32;
  localparam int DW = `DATA_BUS_WIDTH;

`ifdef DBUS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk_i, rst_i;
  logic          req_vld_i, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [2:0]    req_size_i;
  logic          stall_o;
  logic [DW-1:0] rdata_o;
  logic          rdata_vld_o, err_o, misalign_o;
  logic          dbus_req_o, dbus_we_o;
  logic [AW-1:0] dbus_addr_o;
  logic [3:0]    dbus_be_o;
  logic [DW-1:0] dbus_wdata_o;
  logic          dbus_gnt_i, dbus_rvld_i;
  logic [DW-1:0] dbus_rdata_i;

  dbus_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(AW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_vld_i    (req_vld_i),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_size_i   (req_size_i),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .rdata_vld_o  (rdata_vld_o),
    .err_o        (err_o),
    .misalign_o   (misalign_o),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_gnt_i   (dbus_gnt_i),
    .dbus_rvld_i  (dbus_rvld_i),
    .dbus_rdata_i (dbus_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one access record) ----------------
  bit            m_on = 1'b0;
  bit            m_busy, m_granted, m_fin, m_rv, m_er, m_mis, m_done_now;
  int            m_age;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;
  logic [DW-1:0] m_wdata, m_rdata;

  function automatic logic [3:0] exp_be(input logic [2:0] size, input logic [AW-1:0] a);
    int off;
    off = int'(a % 4);
    if ($countones(size) != 1) return 4'h0;
    if (size[0]) return 4'(1 << off);
    if (size[1]) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic bit exp_misaligned(input logic [2:0] size, input logic [AW-1:0] a);
    return ((size == 3'b010) && (a % 2 != 0)) || ((size == 3'b100) && (a % 4 != 0));
  endfunction

  // Compare the DUT against the model mid-cycle, then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge clk_i) begin
    if (m_on) begin
      check("stall", stall_o, m_busy ? 1 : (m_fin ? 0 : req_vld_i));
      check("dbus_req", dbus_req_o, m_busy && !m_granted);
      if (m_busy && !m_granted) begin
        check("dbus_addr", dbus_addr_o, m_addr);
        check("dbus_be", dbus_be_o, m_be);
        check("dbus_we", dbus_we_o, m_we);
        check("dbus_wdata", dbus_wdata_o, m_wdata);
      end
      check("rdata_vld", rdata_vld_o, m_fin && m_rv);
      check("err", err_o, m_fin && m_er);
      check("misalign", misalign_o, m_fin && m_mis);
      check("rdata", rdata_o, m_rdata);
    end

    if (rst_i) begin
      m_busy = 0; m_granted = 0; m_fin = 0; m_rv = 0; m_er = 0; m_mis = 0;
      m_age = 0; m_we = 0; m_addr = '0; m_be = '0; m_wdata = '0; m_rdata = '0;
      m_on = 1'b1;
    end else if (m_on) begin
      if (m_fin) begin
        m_fin = 0; m_rv = 0; m_er = 0; m_mis = 0;
      end else if (!m_busy) begin
        if (req_vld_i) begin
          m_we    = req_we_i;
          m_addr  = (req_addr_i / 4) * 4;
          m_be    = exp_be(req_size_i, req_addr_i);
          m_wdata = req_wdata_i;
          if (TRAP && exp_misaligned(req_size_i, req_addr_i)) begin
            m_fin = 1; m_mis = 1;
          end else begin
            m_busy = 1; m_granted = 0; m_age = 0;
          end
        end
      end else begin
        m_done_now = m_granted ? dbus_rvld_i : (dbus_gnt_i && (m_we || dbus_rvld_i));
        if (m_done_now) begin
          if (!m_we) begin
            m_rdata = dbus_rdata_i;
            m_rv    = 1;
          end
          m_busy = 0; m_fin = 1;
        end else if (m_age == TO - 1) begin
          m_busy = 0; m_fin = 1; m_er = 1; m_rdata = '0;
        end else begin
          if (!m_granted && dbus_gnt_i) m_granted = 1;
          m_age++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  task automatic set_req(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] s);
    req_vld_i   = v;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    req_size_i  = s;
  endtask

  task automatic new_instr();
    int r;
    r = int'($urandom % 10);
    set_req(($urandom % 4) != 0, $urandom % 2, $urandom, $urandom, 3'b000);
    if (r < 3)      req_size_i = 3'b001;
    else if (r < 6) req_size_i = 3'b010;
    else if (r < 9) req_size_i = 3'b100;
    else            req_size_i = 3'($urandom % 8);
  endtask

  logic s_stall;

  initial begin
    rst_i = 1'b1;
    set_req(0, 0, '0, '0, 3'b000);
    dbus_gnt_i = 0; dbus_rvld_i = 0; dbus_rdata_i = '0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    mid();
    check("rst_stall", stall_o, 0);
    check("rst_req", dbus_req_o, 0);
    check("rst_addr", dbus_addr_o, 0);
    check("rst_be", dbus_be_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_pulses", {rdata_vld_o, err_o, misalign_o}, 0);

    // Store byte at 0x1003, granted in its first REQ cycle
    tick(); set_req(1, 1, 32'h1003, 32'hAB000000, 3'b001);
    mid();  check("t1_stall_idle", stall_o, 1); check("t1_req_idle", dbus_req_o, 0);
    tick(); dbus_gnt_i = 1;
    mid();  check("t1_req", dbus_req_o, 1); check("t1_addr", dbus_addr_o, 32'h1000);
            check("t1_be", dbus_be_o, 4'b1000); check("t1_we", dbus_we_o, 1);
            check("t1_wdata", dbus_wdata_o, 32'hAB000000); check("t1_stall_req", stall_o, 1);
    tick(); dbus_gnt_i = 0;
    mid();  check("t1_stall_done", stall_o, 0); check("t1_rvld", rdata_vld_o, 0);
    tick(); req_vld_i = 0;

    // Load word at 0x2000: grant on 2nd REQ cycle, data 2 cycles later
    // (data lands on the last counted cycle: completion beats timeout)
    tick(); set_req(1, 0, 32'h2000, 32'h0, 3'b100);
    mid();  check("t2_stall_idle", stall_o, 1);
    tick();
    mid();  check("t2_req0", dbus_req_o, 1);
    tick(); dbus_gnt_i = 1;
    mid();  check("t2_req1", dbus_req_o, 1); check("t2_be", dbus_be_o, 4'hF);
            check("t2_addr", dbus_addr_o, 32'h2000); check("t2_we", dbus_we_o, 0);
    tick(); dbus_gnt_i = 0;
    mid();  check("t2_wait_req", dbus_req_o, 0); check("t2_wait_stall", stall_o, 1);
    tick(); dbus_rvld_i = 1; dbus_rdata_i = 32'hDEADBEEF;
    mid();  check("t2_wait2_stall", stall_o, 1);
    tick(); dbus_rvld_i = 0;
    mid();  check("t2_done_stall", stall_o, 0); check("t2_rvld", rdata_vld_o, 1);
            check("t2_rdata", rdata_o, 32'hDEADBEEF); check("t2_err", err_o, 0);
    tick(); req_vld_i = 0;
    mid();  check("t2_rvld_after", rdata_vld_o, 0); check("t2_rdata_hold", rdata_o, 32'hDEADBEEF);

    // Load half at 0x2002, grant and data in the same REQ cycle
    tick(); set_req(1, 0, 32'h2002, 32'h0, 3'b010);
    mid();  check("t3_stall_idle", stall_o, 1);
    tick(); dbus_gnt_i = 1; dbus_rvld_i = 1; dbus_rdata_i = 32'h12345678;
    mid();  check("t3_be", dbus_be_o, 4'b1100); check("t3_addr", dbus_addr_o, 32'h2000);
            check("t3_stall_req", stall_o, 1);
    tick(); dbus_gnt_i = 0; dbus_rvld_i = 0;
    mid();  check("t3_stall_done", stall_o, 0); check("t3_rvld", rdata_vld_o, 1);
            check("t3_rdata", rdata_o, 32'h12345678);
    tick(); req_vld_i = 0;

    // Reset while waiting for data; late data must be ignored
    tick(); set_req(1, 0, 32'h100, 32'h0, 3'b100);
    mid();
    tick(); dbus_gnt_i = 1;
    mid();  check("t5_req", dbus_req_o, 1);
    tick(); dbus_gnt_i = 0; rst_i = 1;
    mid();  check("t5_wait_stall", stall_o, 1);
    tick(); rst_i = 0; req_vld_i = 0; dbus_rvld_i = 1; dbus_rdata_i = 32'hCAFEF00D;
    mid();  check("t5_stall", stall_o, 0); check("t5_req", dbus_req_o, 0);
            check("t5_rdata", rdata_o, 0); check("t5_addr", dbus_addr_o, 0);
            check("t5_pulses", {rdata_vld_o, err_o}, 0);
    tick(); dbus_rvld_i = 0;
    mid();  check("t5_rvld_late", rdata_vld_o, 0); check("t5_rdata_late", rdata_o, 0);

    // Load word with no data: times out after 4 REQ/WAIT cycles
    tick(); set_req(1, 0, 32'h40, 32'h0, 3'b100);
    mid();
    tick(); dbus_gnt_i = 1;
    mid();
    tick(); dbus_gnt_i = 0;
    mid();  check("t4_err_w1", err_o, 0);
    tick();
    mid();
    tick();
    mid();  check("t4_err_w3", err_o, 0); check("t4_stall_w3", stall_o, 1);
    tick();
    mid();  check("t4_err", err_o, 1); check("t4_rvld", rdata_vld_o, 0);
            check("t4_rdata", rdata_o, 0); check("t4_stall", stall_o, 0);
            check("t4_req", dbus_req_o, 0);
    tick(); req_vld_i = 0;
    mid();  check("t4_err_off", err_o, 0);
    tick(); set_req(1, 1, 32'h80, 32'h55, 3'b100);
    mid();
    tick(); dbus_gnt_i = 1;
    mid();  check("t4_next_req", dbus_req_o, 1); check("t4_next_addr", dbus_addr_o, 32'h80);
    tick(); dbus_gnt_i = 0;
    mid();  check("t4_next_done", {stall_o, err_o}, 0);
    tick(); req_vld_i = 0;

    // Word load at 0x3001
    tick(); set_req(1, 0, 32'h3001, 32'h0, 3'b100);
    mid();  check("t6_stall_idle", stall_o, 1);
`ifdef DBUS_MISALIGN_TRAP_EN
    tick();
    mid();  check("t6_mis", misalign_o, 1); check("t6_req", dbus_req_o, 0);
            check("t6_stall", stall_o, 0); check("t6_pulses", {rdata_vld_o, err_o}, 0);
    tick(); req_vld_i = 0;
    mid();  check("t6_mis_off", misalign_o, 0); check("t6_req_off", dbus_req_o, 0);
`else
    tick(); dbus_gnt_i = 1; dbus_rvld_i = 1; dbus_rdata_i = 32'h0BADF00D;
    mid();  check("t6_req", dbus_req_o, 1); check("t6_be", dbus_be_o, 4'hF);
            check("t6_addr", dbus_addr_o, 32'h3000);
    tick(); dbus_gnt_i = 0; dbus_rvld_i = 0;
    mid();  check("t6_rvld", rdata_vld_o, 1); check("t6_mis", misalign_o, 0);
            check("t6_rdata", rdata_o, 32'h0BADF00D);
    tick(); req_vld_i = 0;
`endif

    // Randomized pipeline and noisy bus
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_i);
      s_stall = stall_o;
      @(posedge clk_i);
      #1;
      if (rst_i) begin
        rst_i = 0;
        req_vld_i = 0;
      end else begin
        if (($urandom % 150) == 0) rst_i = 1;
        if (!req_vld_i || !s_stall) new_instr();
      end
      dbus_gnt_i   = dbus_req_o ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
      dbus_rvld_i  = ($urandom % 2) == 0;
      dbus_rdata_i = $urandom;
    end

    mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
